// File: rtl/pulse_chk_pkg.sv
// Shared types and helpers for the single-pulse checker.
package pulse_chk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // Lower delay bound clamps at zero so a wide tolerance never goes negative.
  function automatic int win_lo(input int exp_d, input int tol);
    return (tol > exp_d) ? 0 : exp_d - tol;
  endfunction

  function automatic int win_hi(input int exp_d, input int tol);
    return exp_d + tol;
  endfunction

endpackage

// File: rtl/single_pulse_checker_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/single_pulse_checker.sv
// Watches pulse_in after reset, measures delay/width of the first pulse and
// latches sticky errors for late, missing, mis-sized or extra pulses.
module single_pulse_checker
  import pulse_chk_pkg::*;
#(
  parameter int EXP_DELAY = 5,
  parameter int EXP_WIDTH = 1,
  parameter int TOL       = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             pulse_seen,
  output logic             done,
  output logic [CNT_W-1:0] meas_delay,
  output logic [CNT_W-1:0] meas_width,
  output logic             err_delay,
  output logic             err_missing,
  output logic             err_width,
  output logic             err_extra
);

  localparam int WIN_LO  = win_lo(EXP_DELAY, TOL);
  localparam int WIN_HI  = win_hi(EXP_DELAY, TOL);
  localparam int MISS_AT = WIN_HI + 1;

  chk_state_e       state_q, state_d;
  logic             pulse_seen_q, pulse_seen_d;
  logic [CNT_W-1:0] meas_delay_q, meas_delay_d;
  logic [CNT_W-1:0] meas_width_q, meas_width_d;
  logic             err_delay_q, err_delay_d;
  logic             err_missing_q, err_missing_d;
  logic             err_width_q, err_width_d;
  logic             err_extra_q, err_extra_d;

  logic [CNT_W-1:0] dly_cnt, wid_cnt;
  logic             cnt_clr, dly_inc, wid_inc;
  int               dly_v, wid_v;

  // Width counter is only ever cleared by reset, so the rising sample takes it 0 -> 1.
  assign cnt_clr = !reset;
  assign dly_inc = (state_q == ST_WAIT) && !pulse_in;
  assign wid_inc = pulse_in && (state_q != ST_DONE);

  sat_counter #(.W(CNT_W)) u_dly_cnt (
    .clk   (clk),
    .clr_i (cnt_clr),
    .inc_i (dly_inc),
    .cnt_o (dly_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wid_cnt (
    .clk   (clk),
    .clr_i (cnt_clr),
    .inc_i (wid_inc),
    .cnt_o (wid_cnt)
  );

  always_comb begin
    dly_v = int'(dly_cnt);
    wid_v = int'(wid_cnt);
  end

  always_comb begin
    state_d       = state_q;
    pulse_seen_d  = 1'b0;
    meas_delay_d  = meas_delay_q;
    meas_width_d  = meas_width_q;
    err_delay_d   = err_delay_q;
    err_missing_d = err_missing_q;
    err_width_d   = err_width_q;
    err_extra_d   = err_extra_q;
    case (state_q)
      ST_WAIT: begin
        if (pulse_in) begin
          meas_delay_d = dly_cnt;
          pulse_seen_d = 1'b1;
          state_d      = ST_HIGH;
          if ((dly_v < WIN_LO) || (dly_v > WIN_HI))
            err_delay_d = 1'b1;
        end else if (dly_v == MISS_AT) begin
          err_missing_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_HIGH: begin
        if (pulse_in) begin
          // Flag an over-long pulse as soon as it is known, not at the fall.
          if (wid_v >= EXP_WIDTH)
            err_width_d = 1'b1;
        end else begin
          meas_width_d = wid_cnt;
          state_d      = ST_DONE;
          if (wid_v != EXP_WIDTH)
            err_width_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (pulse_in)
          err_extra_d = 1'b1;
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_WAIT;
      pulse_seen_q  <= 1'b0;
      meas_delay_q  <= '0;
      meas_width_q  <= '0;
      err_delay_q   <= 1'b0;
      err_missing_q <= 1'b0;
      err_width_q   <= 1'b0;
      err_extra_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulse_seen_q  <= pulse_seen_d;
      meas_delay_q  <= meas_delay_d;
      meas_width_q  <= meas_width_d;
      err_delay_q   <= err_delay_d;
      err_missing_q <= err_missing_d;
      err_width_q   <= err_width_d;
      err_extra_q   <= err_extra_d;
    end
  end

  assign pulse_seen  = pulse_seen_q;
  assign done        = (state_q == ST_DONE);
  assign meas_delay  = meas_delay_q;
  assign meas_width  = meas_width_q;
  assign err_delay   = err_delay_q;
  assign err_missing = err_missing_q;
  assign err_width   = err_width_q;
  assign err_extra   = err_extra_q;

endmodule

// File: tb/tb_single_pulse_checker.sv
// Scoreboarded random/directed bench for single_pulse_checker; two parameter sets share one stimulus.
module tb_single_pulse_checker;

  typedef struct packed {
    logic       ps;
    logic       dn;
    logic [7:0] md;
    logic [7:0] mw;
    logic       ed;
    logic       em;
    logic       ew;
    logic       ex;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pulse_in = 1'b0;

  logic       ps0, dn0, ed0, em0, ew0, ex0;
  logic [7:0] md0, mw0;
  logic       ps1, dn1, ed1, em1, ew1, ex1;
  logic [7:0] md1, mw1;
  obs_t       act0, act1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   smp[$];
  obs_t q0[$];
  obs_t q1[$];

  always #5 clk = ~clk;

  single_pulse_checker dut0 (
    .clk(clk), .reset(rst_n), .pulse_in(pulse_in),
    .pulse_seen(ps0), .done(dn0), .meas_delay(md0), .meas_width(mw0),
    .err_delay(ed0), .err_missing(em0), .err_width(ew0), .err_extra(ex0)
  );

  // Second instance: tolerance wider than the expected delay, two-cycle pulse.
  single_pulse_checker #(.EXP_DELAY(2), .EXP_WIDTH(2), .TOL(3), .CNT_W(8)) dut1 (
    .clk(clk), .reset(rst_n), .pulse_in(pulse_in),
    .pulse_seen(ps1), .done(dn1), .meas_delay(md1), .meas_width(mw1),
    .err_delay(ed1), .err_missing(em1), .err_width(ew1), .err_extra(ex1)
  );

  assign act0 = {ps0, dn0, md0, mw0, ed0, em0, ew0, ex0};
  assign act1 = {ps1, dn1, md1, mw1, ed1, em1, ew1, ex1};

  // Expected outputs from the whole post-reset sample history.
  function automatic obs_t model(input int ed, input int ew, input int tol);
    obs_t e;
    int k, lo, hi, miss, f, r;
    e    = '0;
    k    = smp.size() - 1;
    lo   = (tol > ed) ? 0 : ed - tol;
    hi   = ed + tol;
    miss = hi + 1;
    f    = -1;
    for (int i = 0; i <= k; i++)
      if (smp[i] && f < 0) f = i;
    if (f < 0 || f > miss) begin
      if (k >= miss) begin
        e.em = 1'b1;
        e.dn = 1'b1;
        for (int i = miss + 1; i <= k; i++)
          if (smp[i]) e.ex = 1'b1;
      end
      return e;
    end
    e.md = 8'(f);
    e.ps = (k == f);
    e.ed = (f < lo) || (f > hi);
    r = 0;
    while (f + r <= k && smp[f + r]) r++;
    if (f + r > k) begin
      e.ew = (r > ew);
    end else begin
      e.dn = 1'b1;
      e.mw = 8'(r);
      e.ew = (r != ew);
      for (int i = f + r + 1; i <= k; i++)
        if (smp[i]) e.ex = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input bit rst, input bit p);
    rst_n    = rst;
    pulse_in = p;
    @(posedge clk);
    if (!rst) smp.delete();
    else smp.push_back(p);
    q0.push_back(rst ? model(5, 1, 0) : obs_t'(0));
    q1.push_back(rst ? model(2, 2, 3) : obs_t'(0));
    #1;
  endtask

  task automatic run(input int first, input int width, input int second, input int len);
    bit p;
    repeat (2) step(1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      p = (first >= 0 && i >= first && i < first + width) || (i == second);
      step(1'b1, p);
    end
  endtask

  task automatic chk(input int id, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL dut%0d cyc%0d got ps=%0b dn=%0b md=%0d mw=%0d ed=%0b em=%0b ew=%0b ex=%0b want ps=%0b dn=%0b md=%0d mw=%0d ed=%0b em=%0b ew=%0b ex=%0b",
               id, cyc, a.ps, a.dn, a.md, a.mw, a.ed, a.em, a.ew, a.ex,
               e.ps, e.dn, e.md, e.mw, e.ed, e.em, e.ew, e.ex);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0) chk(0, act0, q0.pop_front());
    if (q1.size() > 0) chk(1, act1, q1.pop_front());
  end

  initial begin
    int first, width, second, len;
    run(5, 1, -1, 12);
    run(3, 1, -1, 10);
    run(5, 3, -1, 14);
    run(-1, 0, 20, 25);
    run(5, 1, 9, 14);
    // Reset dropped while the pulse is high, then a clean pulse.
    repeat (2) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    run(0, 1, -1, 8);
    run(6, 1, -1, 10);
    run(7, 2, -1, 12);
    run(2, 2, -1, 10);
    run(3, 40, -1, 45);
    for (int n = 0; n < 30; n++) begin
      first  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
      width  = $urandom_range(1, 4);
      second = ($urandom_range(0, 1) == 0) ? -1 : first + width + int'($urandom_range(1, 6));
      len    = $urandom_range(12, 24);
      run(first, width, second, len);
    end
    repeat (3) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain got q0=%0d q1=%0d want 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
